arb2_sel: RTL
=============

ARB2_SEL -- requirements
Module: arb2_sel

Interface
REQ-001 Parameter: WIDTH, default 1, data width of both input streams and the output stream.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_valid  input  1  source A has data.
REQ-005 a_data  input  WIDTH  source A payload.
REQ-006 a_ready  output  1  source A payload accepted this cycle.
REQ-007 b_valid  input  1  source B has data.
REQ-008 b_data  input  WIDTH  source B payload.
REQ-009 b_ready  output  1  source B payload accepted this cycle.
REQ-010 o_valid  output  1  output register holds a payload.
REQ-011 o_data  output  WIDTH  output payload.
REQ-012 o_ready  input  1  downstream consumes o_data when o_valid high.
REQ-013 sel  output  1  source of current o_data: 0 = A, 1 = B.

Function
REQ-014 Transfer on an input occurs when x_valid and x_ready are both high at a rising edge; output transfer when o_valid and o_ready are both high.
REQ-015 Two states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-016 load_en = EMPTY, or FULL with o_ready high in the same cycle (pass-through at full throughput).
REQ-017 a_ready and b_ready are combinational from load_en, valids and priority pointer; at most one is high per cycle; neither is high when load_en is low.
REQ-018 Only A valid: grant A. Only B valid: grant B. Both valid: grant the source not granted last (round-robin pointer last_grant).
REQ-019 last_grant updates only on an actual input transfer, to the granted source.
REQ-020 On an input transfer, o_data takes the selected payload and sel takes the granted source at the same edge; latency input to o_valid is exactly 1 cycle.
REQ-021 Transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL on output transfer with input transfer, or on o_ready low.
REQ-022 While FULL and o_ready low, o_data and sel are held stable; valid inputs are not accepted.
REQ-023 Input valid held without acceptance is not dropped; it is granted in a later cycle by REQ-018.
REQ-024 No input valid and output consumed: go EMPTY, o_data and sel retain last value.
REQ-025 Throughput: one transfer per cycle sustained when o_ready held high; with both sources valid, grants strictly alternate A,B,A,B.

Reset
REQ-026 On rst high, immediately, without waiting for clk: state EMPTY, o_valid=0, o_data=0, sel=0, last_grant=1 (A wins first contention).
REQ-027 a_ready and b_ready are 0 while rst is high.
REQ-028 rst asserted while FULL discards the held payload; no output transfer completes at that edge.

Structure
REQ-029 Shared package arb_pkg holds: state encoding (EMPTY=0, FULL=1), source codes SRC_A=0 and SRC_B=1.
REQ-030 Datapath selection uses one instance of the existing Mux sub-module (parameter WIDTH, a=a_data, b=b_data, s=grant), output registered in arb2_sel.
REQ-031 Arbitration and state logic are inline; no further sub-modules.

Verification
REQ-032 Reset: rst=1 mid-FULL with o_data=0x5 -> o_valid, o_data, sel go 0 asynchronously; a_ready=b_ready=0.
REQ-033 Single source: WIDTH=4, a_valid=1 a_data=6, o_ready=1 -> a_ready=1, next edge o_valid=1 o_data=6 sel=0; b_ready stays 0.
REQ-034 Contention: a_data=6, b_data=5 both valid, o_ready=1 for 4 cycles after reset -> outputs 6,5,6,5 with sel 0,1,0,1.
REQ-035 Backpressure: FULL with o_data=6, o_ready=0 for 3 cycles, b_valid=1 -> o_data stays 6, b_ready=0; o_ready=1 -> next edge o_data=5 sel=1.
REQ-036 Drain: FULL, o_ready=1, no input valid -> next edge o_valid=0; a_valid next cycle -> o_valid=1 one cycle later.
REQ-037 Pointer hold: grant A alone, then both valid -> B granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the two-source round-robin output register.
package arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/Mux.sv
// Two-input payload selector: s=0 picks a, s=1 picks b.
module Mux #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/arb2_sel.sv
// Two-source round-robin arbiter feeding a single-entry output register
// with full-throughput pass-through when downstream is ready.
module arb2_sel
   import arb_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             o_ready,
   output logic             sel
);

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic             sel_q, sel_d;

   logic             load_en;
   logic             grant;
   logic             in_xfer;
   logic [WIDTH-1:0] mux_y;

   Mux #(
      .WIDTH(WIDTH)
   ) u_mux (
      .a(a_data),
      .b(b_data),
      .s(grant),
      .y(mux_y)
   );

   always_comb begin
      load_en      = (state_q == EMPTY) || o_ready;
      grant        = SRC_A;
      state_d      = state_q;
      last_grant_d = last_grant_q;
      o_data_d     = o_data_q;
      sel_d        = sel_q;

      // Under contention the source that did not win last time goes first.
      if (a_valid && b_valid) begin
         grant = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
      end else if (b_valid) begin
         grant = SRC_B;
      end

      a_ready = !rst && load_en && a_valid && (grant == SRC_A);
      b_ready = !rst && load_en && b_valid && (grant == SRC_B);
      in_xfer = a_ready || b_ready;

      if (in_xfer) begin
         state_d      = FULL;
         last_grant_d = grant;
         o_data_d     = mux_y;
         sel_d        = grant;
      end else if ((state_q == FULL) && o_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         last_grant_q <= SRC_B;
         o_data_q     <= '0;
         sel_q        <= SRC_A;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         o_data_q     <= o_data_d;
         sel_q        <= sel_d;
      end
   end

   assign o_valid = (state_q == FULL);
   assign o_data  = o_data_q;
   assign sel     = sel_q;

endmodule
